// File: rtl/axi_mst_initiator.sv
// +----------------------------------------------------------------------------+
// | axi_mst_initiator                                                          |
// | AXI3-style master traffic initiator: command port in, AW/W/AR out, B/R     |
// | sunk with outstanding tracking, completion counters and a sticky error.    |
// | Optional: AXI_MST_RLAST_CHK_EN adds in-order rid / rlast position checking.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_mst_initiator #(
  parameter int          AXI_ADDR_W   = 32,
  parameter int          AXI_ID_W     = 4,
  parameter int          AXI_DATA_W   = 32,
  parameter int          MST_OSTD_NUM = 4,
  parameter logic [31:0] WDATA_SEED   = 32'h1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [AXI_ADDR_W-1:0]   cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic [AXI_ID_W-1:0]     cmd_id,
  // write address
  output logic                    awvalid,
  input  logic                    awready,
  output logic [AXI_ADDR_W-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [AXI_ID_W-1:0]     awid,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  // write data
  output logic                    wvalid,
  input  logic                    wready,
  output logic [AXI_ID_W-1:0]     wid,
  output logic [AXI_DATA_W-1:0]   wdata,
  output logic [AXI_DATA_W/8-1:0] wstrb,
  output logic                    wlast,
  // write response
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [AXI_ID_W-1:0]     bid,
  input  logic [1:0]              bresp,
  // read address
  output logic                    arvalid,
  input  logic                    arready,
  output logic [AXI_ADDR_W-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [AXI_ID_W-1:0]     arid,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  // read data
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [AXI_ID_W-1:0]     rid,
  input  logic [AXI_DATA_W-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  // status
  output logic [15:0]             wr_done_cnt,
  output logic [15:0]             rd_done_cnt,
  output logic                    err
);

  localparam int                  c_LOG_N     = $clog2(MST_OSTD_NUM);
  localparam int                  c_OSTD_W    = c_LOG_N + 1;
  localparam logic [c_OSTD_W-1:0] c_OSTD_MAX  = c_OSTD_W'(MST_OSTD_NUM);
  localparam logic [c_OSTD_W-1:0] c_OSTD_ONE  = c_OSTD_W'(1);
  localparam logic [2:0]          c_AXSIZE    = 3'($clog2(AXI_DATA_W / 8));
  localparam logic [1:0]          c_BURST_INC = 2'b01;
  localparam int                  c_REP       = (AXI_DATA_W + 31) / 32;

  // Galois form of x^32+x^22+x^2+x+1, shifting towards bit 0
  function automatic logic [31:0] f_lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  logic                  r_awvalid, r_arvalid, r_resp_rdy, r_err;
  logic [AXI_ADDR_W-1:0] r_awaddr, r_araddr;
  logic [3:0]            r_awlen, r_arlen;
  logic [AXI_ID_W-1:0]   r_awid, r_arid;
  logic [c_OSTD_W-1:0]   r_wr_ostd, r_rd_ostd, w_wr_ostd_nxt, w_rd_ostd_nxt;
  logic [15:0]           r_wr_done, r_rd_done;
  logic [31:0]           r_lfsr;
  logic [c_REP*32-1:0]   w_wdata_rep;

  logic w_wr_acc, w_rd_acc, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_rl_hs;
  logic w_err_set, w_rchk_err;

  // W burst FIFO
  logic [3:0]            r_wf_len [MST_OSTD_NUM];
  logic [AXI_ID_W-1:0]   r_wf_id  [MST_OSTD_NUM];
  logic [c_OSTD_W-1:0]   r_wf_wp, r_wf_rp;
  logic [3:0]            r_wbeat, w_wf_head_len;
  logic                  w_wf_empty, w_wf_full, w_wf_push, w_wf_pop, w_wvalid, w_wlast;

  assign cmd_ready = cmd_write ? (!r_awvalid && (r_wr_ostd < c_OSTD_MAX))
                               : (!r_arvalid && (r_rd_ostd < c_OSTD_MAX));

  assign w_wr_acc = cmd_valid && cmd_ready && cmd_write;
  assign w_rd_acc = cmd_valid && cmd_ready && !cmd_write;
  assign w_aw_hs  = r_awvalid && awready;
  assign w_ar_hs  = r_arvalid && arready;
  assign w_w_hs   = w_wvalid && wready;
  assign w_b_hs   = bvalid && r_resp_rdy;
  assign w_r_hs   = rvalid && r_resp_rdy;
  assign w_rl_hs  = w_r_hs && rlast;

  assign awvalid = r_awvalid;
  assign awaddr  = r_awaddr;
  assign awlen   = r_awlen;
  assign awid    = r_awid;
  assign awsize  = c_AXSIZE;
  assign awburst = c_BURST_INC;
  assign arvalid = r_arvalid;
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arid    = r_arid;
  assign arsize  = c_AXSIZE;
  assign arburst = c_BURST_INC;
  assign bready  = r_resp_rdy;
  assign rready  = r_resp_rdy;
  assign wr_done_cnt = r_wr_done;
  assign rd_done_cnt = r_rd_done;
  assign err     = r_err;

  // Payload only changes on accept, which is blocked while the valid is up
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awaddr <= '0;
      r_awlen  <= '0;
      r_awid   <= '0;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_arid   <= '0;
    end else begin
      if (w_wr_acc) begin
        r_awaddr <= cmd_addr;
        r_awlen  <= cmd_len;
        r_awid   <= cmd_id;
      end
      if (w_rd_acc) begin
        r_araddr <= cmd_addr;
        r_arlen  <= cmd_len;
        r_arid   <= cmd_id;
      end
    end
  end

  always_comb begin
    w_wr_ostd_nxt = r_wr_ostd;
    w_rd_ostd_nxt = r_rd_ostd;
    if (w_wr_acc && !w_b_hs) begin
      w_wr_ostd_nxt = r_wr_ostd + c_OSTD_ONE;
    end else if (!w_wr_acc && w_b_hs && (r_wr_ostd != '0)) begin
      w_wr_ostd_nxt = r_wr_ostd - c_OSTD_ONE;
    end
    if (w_rd_acc && !w_rl_hs) begin
      w_rd_ostd_nxt = r_rd_ostd + c_OSTD_ONE;
    end else if (!w_rd_acc && w_rl_hs && (r_rd_ostd != '0)) begin
      w_rd_ostd_nxt = r_rd_ostd - c_OSTD_ONE;
    end
  end

  assign w_err_set = (w_b_hs && ((bresp != 2'b00) || (r_wr_ostd == '0)))
                  || (w_r_hs && (rresp != 2'b00))
                  || (w_rl_hs && (r_rd_ostd == '0))
                  || w_rchk_err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awvalid  <= 1'b0;
      r_arvalid  <= 1'b0;
      r_resp_rdy <= 1'b0;
      r_wr_ostd  <= '0;
      r_rd_ostd  <= '0;
      r_wr_done  <= '0;
      r_rd_done  <= '0;
      r_err      <= 1'b0;
    end else if (srst) begin
      r_awvalid  <= 1'b0;
      r_arvalid  <= 1'b0;
      r_resp_rdy <= 1'b0;
      r_wr_ostd  <= '0;
      r_rd_ostd  <= '0;
      r_wr_done  <= '0;
      r_rd_done  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_resp_rdy <= 1'b1;
      if (w_wr_acc) begin
        r_awvalid <= 1'b1;
      end else if (w_aw_hs) begin
        r_awvalid <= 1'b0;
      end
      if (w_rd_acc) begin
        r_arvalid <= 1'b1;
      end else if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end
      r_wr_ostd <= w_wr_ostd_nxt;
      r_rd_ostd <= w_rd_ostd_nxt;
      if (w_b_hs) begin
        r_wr_done <= r_wr_done + 16'd1;
      end
      if (w_rl_hs) begin
        r_rd_done <= r_rd_done + 16'd1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_wf_empty    = (r_wf_wp == r_wf_rp);
  assign w_wf_full     = (r_wf_wp[c_LOG_N-1:0] == r_wf_rp[c_LOG_N-1:0])
                      && (r_wf_wp[c_LOG_N] != r_wf_rp[c_LOG_N]);
  assign w_wf_push     = w_aw_hs && !w_wf_full;
  assign w_wf_head_len = r_wf_len[r_wf_rp[c_LOG_N-1:0]];
  assign w_wvalid      = !w_wf_empty;
  assign w_wlast       = w_wvalid && (r_wbeat == w_wf_head_len);
  assign w_wf_pop      = w_w_hs && w_wlast;

  assign wvalid = w_wvalid;
  assign wlast  = w_wlast;
  assign wid    = r_wf_id[r_wf_rp[c_LOG_N-1:0]];
  assign wstrb  = '1;

  always_ff @(posedge aclk) begin
    if (w_wf_push) begin
      r_wf_len[r_wf_wp[c_LOG_N-1:0]] <= r_awlen;
      r_wf_id[r_wf_wp[c_LOG_N-1:0]]  <= r_awid;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wf_wp <= '0;
      r_wf_rp <= '0;
      r_wbeat <= '0;
      r_lfsr  <= WDATA_SEED;
    end else if (srst) begin
      r_wf_wp <= '0;
      r_wf_rp <= '0;
      r_wbeat <= '0;
      r_lfsr  <= WDATA_SEED;
    end else begin
      if (w_wf_push) begin
        r_wf_wp <= r_wf_wp + c_OSTD_ONE;
      end
      if (w_wf_pop) begin
        r_wf_rp <= r_wf_rp + c_OSTD_ONE;
      end
      if (w_w_hs) begin
        r_wbeat <= w_wlast ? 4'd0 : r_wbeat + 4'd1;
        r_lfsr  <= f_lfsr_next(r_lfsr);
      end
    end
  end

  // Wider data buses repeat the 32-bit pattern across lanes
  assign w_wdata_rep = {c_REP{r_lfsr}};
  assign wdata       = w_wdata_rep[AXI_DATA_W-1:0];

`ifdef AXI_MST_RLAST_CHK_EN
  logic [3:0]          r_af_len [MST_OSTD_NUM];
  logic [AXI_ID_W-1:0] r_af_id  [MST_OSTD_NUM];
  logic [c_OSTD_W-1:0] r_af_wp, r_af_rp;
  logic [3:0]          r_rbeat, w_af_head_len;
  logic [AXI_ID_W-1:0] w_af_head_id;
  logic                w_af_empty, w_af_full, w_af_push, w_af_pop;
  logic                w_unused;

  assign w_af_empty    = (r_af_wp == r_af_rp);
  assign w_af_full     = (r_af_wp[c_LOG_N-1:0] == r_af_rp[c_LOG_N-1:0])
                      && (r_af_wp[c_LOG_N] != r_af_rp[c_LOG_N]);
  assign w_af_push     = w_ar_hs && !w_af_full;
  assign w_af_pop      = w_rl_hs && !w_af_empty;
  assign w_af_head_len = r_af_len[r_af_rp[c_LOG_N-1:0]];
  assign w_af_head_id  = r_af_id[r_af_rp[c_LOG_N-1:0]];

  // Responses are in order and non-interleaved, so the head describes every beat
  assign w_rchk_err = w_r_hs && (w_af_empty
                              || (rid != w_af_head_id)
                              || (rlast && (r_rbeat != w_af_head_len))
                              || (!rlast && (r_rbeat == w_af_head_len)));

  always_ff @(posedge aclk) begin
    if (w_af_push) begin
      r_af_len[r_af_wp[c_LOG_N-1:0]] <= r_arlen;
      r_af_id[r_af_wp[c_LOG_N-1:0]]  <= r_arid;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_af_wp <= '0;
      r_af_rp <= '0;
      r_rbeat <= '0;
    end else if (srst) begin
      r_af_wp <= '0;
      r_af_rp <= '0;
      r_rbeat <= '0;
    end else begin
      if (w_af_push) begin
        r_af_wp <= r_af_wp + c_OSTD_ONE;
      end
      if (w_af_pop) begin
        r_af_rp <= r_af_rp + c_OSTD_ONE;
      end
      if (w_r_hs) begin
        r_rbeat <= rlast ? 4'd0 : r_rbeat + 4'd1;
      end
    end
  end

  assign w_unused = ^{rdata, bid};
`else
  logic w_unused;

  assign w_rchk_err = 1'b0;
  assign w_unused   = ^{rid, rdata, bid};
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_mst_initiator.sv
// +----------------------------------------------------------------------------+
// | tb_axi_mst_initiator                                                       |
// | Scoreboard bench for axi_mst_initiator (AW/W/AR payloads, W data, status). |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_axi_mst_initiator;

  localparam logic [31:0] c_SEED = 32'h1;

  logic        aclk = 1'b0;
  logic        aresetn, srst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len, cmd_id;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awlen, awid;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        wvalid, wready, wlast;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arlen, arid;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [15:0] wr_done_cnt, rd_done_cnt;
  logic        err;

  axi_mst_initiator #(
    .AXI_ADDR_W(32), .AXI_ID_W(4), .AXI_DATA_W(32), .MST_OSTD_NUM(4), .WDATA_SEED(c_SEED)
  ) u_dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awid(awid),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt), .err(err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
  } ax_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } wb_t;

  ax_t awq[$], arq[$];
  wb_t wq[$];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_lfsr;
  int          exp_wr_done, exp_rd_done;
  logic        exp_err;
  logic        stall_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bit-serial form of the x^32+x^22+x^2+x+1 Galois register
  function automatic logic [31:0] model_lfsr(input logic [31:0] s);
    logic        fb;
    logic [31:0] n;
    fb = s[0];
    n = s >> 1;
    n[31] = fb;
    n[21] = n[21] ^ fb;
    n[1]  = n[1] ^ fb;
    n[0]  = n[0] ^ fb;
    return n;
  endfunction

  task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                          input logic [3:0] id);
    ax_t a;
    wb_t b;
    a.addr = addr; a.len = len; a.id = id;
    if (wr) begin
      awq.push_back(a);
      for (int i = 0; i <= int'(len); i++) begin
        b.id = id; b.data = m_lfsr; b.last = (i == int'(len));
        wq.push_back(b);
        m_lfsr = model_lfsr(m_lfsr);
      end
    end else begin
      arq.push_back(a);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                          input logic [3:0] id);
    logic acc;
    acc = 1'b0;
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge aclk);
      if (cmd_ready) begin
        acc = 1'b1;
        push_exp(wr, addr, len, id);
      end
      @(posedge aclk); #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", acc, 1'b1);
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
    @(posedge aclk); #1;
    bvalid = 1'b1; bid = id; bresp = resp;
    @(negedge aclk);
    check("bready", bready, 1'b1);
    @(posedge aclk); #1;
    bvalid = 1'b0; bresp = 2'b00;
    exp_wr_done++;
  endtask

  task automatic send_r(input logic [3:0] id, input int nbeats, input int last_at);
    for (int b = 0; b < nbeats; b++) begin
      @(posedge aclk); #1;
      rvalid = 1'b1; rid = id; rresp = 2'b00; rlast = (b == last_at);
      rdata = $urandom;
      if (b == last_at) exp_rd_done++;
    end
    @(posedge aclk); #1;
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic wait_w_drain();
    for (int k = 0; k < 2000 && (wq.size() != 0 || awvalid || wvalid); k++) @(negedge aclk);
    check("w_drain", wq.size(), 0);
  endtask

  task automatic wait_ar_done();
    for (int k = 0; k < 500 && (arq.size() != 0 || arvalid); k++) @(negedge aclk);
    check("ar_drain", arq.size(), 0);
  endtask

  task automatic check_status(input string tag);
    @(negedge aclk);
    check({tag, "_wr_done"}, wr_done_cnt, exp_wr_done[15:0]);
    check({tag, "_rd_done"}, rd_done_cnt, exp_rd_done[15:0]);
    check({tag, "_err"}, err, exp_err);
  endtask

  // Slave-side ready generator: always ready, or random stalls
  initial begin
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      if (stall_en) begin
        awready = 1'($urandom_range(0, 1));
        wready  = 1'($urandom_range(0, 1));
        arready = 1'($urandom_range(0, 1));
      end else begin
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pops and stall-stability checks
  logic        aw_hs_prev = 1'b0, aw_st = 1'b0, ar_st = 1'b0, w_st = 1'b0;
  logic [39:0] aw_sv, ar_sv;
  logic [36:0] w_sv;

  always @(negedge aclk) begin
    ax_t e;
    wb_t b;
    if (!aresetn || srst) begin
      aw_hs_prev = 1'b0; aw_st = 1'b0; ar_st = 1'b0; w_st = 1'b0;
    end else begin
      if (aw_hs_prev) check("aw_drop", awvalid, 1'b0);
      if (aw_st) check("aw_stable", {awvalid, awaddr, awlen, awid}, {1'b1, aw_sv});
      if (ar_st) check("ar_stable", {arvalid, araddr, arlen, arid}, {1'b1, ar_sv});
      if (w_st)  check("w_stable", {wvalid, wid, wdata, wlast}, {1'b1, w_sv});
      aw_hs_prev = awvalid && awready;
      aw_st = awvalid && !awready; aw_sv = {awaddr, awlen, awid};
      ar_st = arvalid && !arready; ar_sv = {araddr, arlen, arid};
      w_st  = wvalid && !wready;   w_sv  = {wid, wdata, wlast};
      if (awvalid && awready) begin
        if (awq.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
        else begin
          e = awq.pop_front();
          check("aw_payload", {awaddr, awlen, awid}, {e.addr, e.len, e.id});
        end
      end
      if (arvalid && arready) begin
        if (arq.size() == 0) check("ar_unexpected", 1'b1, 1'b0);
        else begin
          e = arq.pop_front();
          check("ar_payload", {araddr, arlen, arid}, {e.addr, e.len, e.id});
        end
      end
      if (wvalid && wready) begin
        if (wq.size() == 0) check("w_unexpected", 1'b1, 1'b0);
        else begin
          b = wq.pop_front();
          check("w_beat", {wid, wdata, wlast}, {b.id, b.data, b.last});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; srst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    bvalid = 1'b0; bid = '0; bresp = '0;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    m_lfsr = c_SEED; exp_wr_done = 0; exp_rd_done = 0; exp_err = 1'b0;

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("rst_bready", {bready, rready}, 2'b00);
    check("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
    check("rst_wdata", wdata, c_SEED);
    check("const_ax", {awsize, awburst, arsize, arburst}, {3'd2, 2'b01, 3'd2, 2'b01});
    check("const_wstrb", wstrb, 4'hf);
    check_status("rst");
    check("post_rst_ready", {bready, rready}, 2'b11);

    // single write
    send_cmd(1'b1, 32'h100, 4'd3, 4'd2);
    wait_w_drain();
    send_b(4'd2, 2'b00);
    check_status("single_wr");

    // fill outstanding writes, then release one slot with a B
    for (int i = 0; i < 4; i++) send_cmd(1'b1, 32'h1000 + 32'(i * 16), 4'd0, 4'(i));
    repeat (3) @(negedge aclk);
    check("ostd_full", cmd_ready, 1'b0);
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1040; cmd_len = 4'd1; cmd_id = 4'd4;
    bvalid = 1'b1; bid = 4'd0; bresp = 2'b00;
    @(negedge aclk);
    check("full_hold", cmd_ready, 1'b0);
    @(posedge aclk); #1;
    bvalid = 1'b0; exp_wr_done++;
    @(negedge aclk);
    check("ready_after_b", cmd_ready, 1'b1);
    if (cmd_ready) push_exp(1'b1, 32'h1040, 4'd1, 4'd4);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    wait_w_drain();

    // same-cycle accept and B at wr_ostd=2
    send_b(4'd1, 2'b00);
    send_b(4'd2, 2'b00);
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3000; cmd_len = 4'd1; cmd_id = 4'd7;
    bvalid = 1'b1; bid = 4'd3; bresp = 2'b00;
    @(negedge aclk);
    check("sc_ready", {cmd_ready, bready}, 2'b11);
    if (cmd_ready) push_exp(1'b1, 32'h3000, 4'd1, 4'd7);
    @(posedge aclk); #1;
    cmd_valid = 1'b0; bvalid = 1'b0; exp_wr_done++;
    send_cmd(1'b1, 32'h3100, 4'd0, 4'd8);
    repeat (2) @(negedge aclk);
    check("ostd3_ready", cmd_ready, 1'b1);
    send_cmd(1'b1, 32'h3200, 4'd0, 4'd9);
    repeat (2) @(negedge aclk);
    check("ostd4_full", cmd_ready, 1'b0);
    wait_w_drain();
    for (int i = 0; i < 4; i++) send_b(4'(i), 2'b00);
    check_status("sc");

    // read burst and a write under random ready stalls
    stall_en = 1'b1;
    send_cmd(1'b0, 32'h2000, 4'd7, 4'd5);
    send_cmd(1'b1, 32'h4000, 4'd7, 4'd9);
    wait_ar_done();
    send_r(4'd5, 8, 7);
    wait_w_drain();
    stall_en = 1'b0;
    send_b(4'd9, 2'b00);
    check_status("rd_stall");

    // error response is sticky
    send_cmd(1'b1, 32'h5000, 4'd0, 4'd3);
    wait_w_drain();
    send_b(4'd3, 2'b10);
    exp_err = 1'b1;
    check_status("bresp_err");
    repeat (5) @(negedge aclk);
    check("err_sticky", err, 1'b1);

    // srst in the middle of a long W burst
    send_cmd(1'b1, 32'h6000, 4'd15, 4'd4);
    repeat (4) @(posedge aclk);
    #1 srst = 1'b1;
    @(posedge aclk); #1;
    srst = 1'b0;
    awq.delete(); wq.delete(); arq.delete();
    m_lfsr = c_SEED; exp_wr_done = 0; exp_rd_done = 0; exp_err = 1'b0;
    @(negedge aclk);
    check("srst_valids", {awvalid, wvalid, arvalid}, 3'b000);
    check("srst_wdata", wdata, c_SEED);
    check_status("srst");

    // early rlast
    send_cmd(1'b0, 32'h7000, 4'd3, 4'd6);
    wait_ar_done();
    send_r(4'd6, 3, 2);
`ifdef AXI_MST_RLAST_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check_status("early_rlast");

    check("queues_empty", awq.size() + wq.size() + arq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_mst_initiator.md
Name: axi_mst_initiator

Overview:
- Synthesizable AXI3-style master traffic initiator for the crossbar testbench; the issuing end of the slave responder's AW/W/B/AR/R interface.
- Accepts write/read commands on a simple valid/ready port and drives AW+W or AR.
- Sinks B/R responses, tracks outstanding transactions per direction, and reports completion counts plus a sticky error flag.

Parameters:
- AXI_ADDR_W, 32, address width
- AXI_ID_W, 4, ID width
- AXI_DATA_W, 32, data width
- MST_OSTD_NUM, 4, max outstanding writes and max outstanding reads; power of 2, ≥2
- WDATA_SEED, 32'h1, non-zero LFSR seed for write data

Ports:
- aclk  in  1  clock
- aresetn  in  1  async reset, active-low
- srst  in  1  sync reset, active-high; same effect as aresetn
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when both valid and ready are high
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AXI_ADDR_W  burst address
- cmd_len  in  4  beats-1
- cmd_id  in  AXI_ID_W  transaction ID
- awvalid/awready  out/in  1  AW handshake
- awaddr  out  AXI_ADDR_W; awlen  out  4; awid  out  AXI_ID_W; awsize  out  3; awburst  out  2
- wvalid/wready  out/in  1; wid  out  AXI_ID_W; wdata  out  AXI_DATA_W; wstrb  out  AXI_DATA_W/8; wlast  out  1
- bvalid/bready  in/out  1; bid  in  AXI_ID_W; bresp  in  2
- arvalid/arready  out/in  1; araddr  out  AXI_ADDR_W; arlen  out  4; arid  out  AXI_ID_W; arsize  out  3; arburst  out  2
- rvalid/rready  in/out  1; rid  in  AXI_ID_W; rdata  in  AXI_DATA_W; rresp  in  2; rlast  in  1
- wr_done_cnt  out  16  completed writes (B handshakes)
- rd_done_cnt  out  16  completed reads (rlast handshakes)
- err  out  1  sticky error

Behaviour:
- Reset (aresetn low or srst high): all valids 0; bready=rready=0; counters, pointers, err = 0; wdata=WDATA_SEED. First cycle after reset: bready=rready=1, held at 1 thereafter.
- Constant outputs: awsize/arsize = log2(AXI_DATA_W/8); awburst/arburst = 2'b01 (INCR); wstrb all ones.
- cmd_ready:
  - Write: !awvalid && wr_ostd<MST_OSTD_NUM.
  - Read: !arvalid && rd_ostd<MST_OSTD_NUM.
  - Combinational on cmd_write.
- Write command accept: AW registers load; awvalid=1 next cycle. AW payload stays stable until the awvalid&&awready cycle; awvalid drops the cycle after.
- Read command accept: AR registers load; arvalid=1 next cycle, same stability rule as AW.
- wr_ostd (width log2(MST_OSTD_NUM)+1):
  - +1 on write accept; -1 on bvalid&&bready; unchanged if both occur in the same cycle.
  - Never exceeds MST_OSTD_NUM; a B with wr_ostd==0 sets err.
- rd_ostd: same rules, using read accept and rvalid&&rready&&rlast.
- W burst FIFO:
  - Depth MST_OSTD_NUM, entries {len,id}, pushed on the AW handshake.
  - Cannot overflow, because wr_ostd gates accepts.
  - Pointers wrap modulo depth; full/empty via an extra pointer bit.
- W channel:
  - wvalid = FIFO non-empty; wid = head id.
  - Beat counter counts W handshakes; wlast = wvalid && beat==head len.
  - On wlast handshake: pop the FIFO and clear the beat counter. A push and a pop in the same cycle are both honoured.
  - W is never issued before its AW handshake.
- wdata: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advances on each W handshake; wdata holds while wvalid&&!wready.
- Completion counters: wr_done_cnt and rd_done_cnt wrap at 16 bits.
- err: set on any bresp!=0 or rresp!=0 handshake, or on an underflow. Cleared only by reset.
- Reset mid-burst: all state is discarded; no partial-burst recovery.

Optional Feature:
- AXI_MST_RLAST_CHK_EN defined:
  - Adds an AR-order FIFO (depth MST_OSTD_NUM, entries {len,id}), pushed on the AR handshake.
  - Adds an R beat counter.
  - err sets on any of: rid != head id; rlast at beat != head len; beat == head len without rlast.
  - Pop on the rlast handshake. Responses are assumed in order, non-interleaved.
- Undefined: rid and beat position are not checked; rlast only decrements rd_ostd and increments rd_done_cnt.

Test Plan:
- Single write, addr=0x100, len=3, id=2, awready/wready/bready=1, bresp=0 → awvalid 1 cycle; 4 W beats with wid=2; wlast on the 4th; wdata sequence matches the LFSR from the seed; wr_done_cnt=1, err=0.
- 5 back-to-back write commands, MST_OSTD_NUM=4, no B returned → cmd_ready=0 after the 4th accept; 1 B handshake → 5th command accepted the next cycle.
- Read len=7, id=5, slave returns 8 beats with rlast on the 8th → rd_done_cnt=1, err=0; random wready/arready stalls → AR/W payload stays stable throughout the stall.
- Same-cycle write accept and B handshake at wr_ostd=2 → wr_ostd stays 2.
- bresp=2'b10 on one write → err=1 and stays 1 until srst; srst pulse mid-W burst → wvalid=0 next cycle and all counters 0.
- With AXI_MST_RLAST_CHK_EN: read len=3, rlast on beat 2 → err=1. Without the macro, the same stimulus → err=0, rd_done_cnt=1.
